// File: rtl/tcm_pkg.sv
// Shared constants and helpers for the dual-port tightly coupled memory.
// Parity storage is enabled by defining TCM_PARITY_EN.
package tcm_pkg;

    localparam int TCM_ADDR_W_DEF     = 8;
    localparam int TCM_DATA_W_DEF     = 32;
    localparam int TCM_STARVE_MAX_DEF = 4;
    localparam int TCM_STARVE_W       = 4;

    // Even parity: the stored bit makes the total count of ones in lane+bit even.
    function automatic logic byte_parity(input logic [7:0] i_byte);
        return ^i_byte;
    endfunction

endpackage

// File: rtl/tcm_arb.sv
// Single-grant arbiter between instruction and data ports, with a starvation
// counter that forces an instruction grant after STARVE_MAX lost conflicts.
module tcm_arb
    import tcm_pkg::*;
#(
    parameter int STARVE_MAX = TCM_STARVE_MAX_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_i_req,
    input  logic i_d_req,
    output logic o_i_grant,
    output logic o_d_grant
);

    logic [TCM_STARVE_W-1:0] r_starve;
    logic                    w_conflict;

    assign w_conflict = i_i_req & i_d_req;

    always_comb begin
        o_i_grant = 1'b0;
        o_d_grant = 1'b0;
        if (!i_reset) begin
            if (w_conflict) begin
                if (r_starve == TCM_STARVE_W'(STARVE_MAX)) begin
                    o_i_grant = 1'b1;
                end else begin
                    o_d_grant = 1'b1;
                end
            end else begin
                o_i_grant = i_i_req;
                o_d_grant = i_d_req;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve <= '0;
        end else if (o_i_grant) begin
            r_starve <= '0;
        end else if (w_conflict) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule

// File: rtl/tcm_dual.sv
// Dual-port (instruction/data) TCM over one single-port array, one access per cycle.
// Define TCM_PARITY_EN to store per-byte even parity and report read errors.
module tcm_dual
    import tcm_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = TCM_ADDR_W_DEF,
    parameter int DATA_WIDTH     = TCM_DATA_W_DEF,
    parameter int STARVE_MAX     = TCM_STARVE_MAX_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_i_req,
    input  logic [MEM_ADDR_WIDTH-1:0] i_i_addr,
    output logic                      o_i_stall,
    output logic                      o_i_ack,
    output logic                      o_i_err,
    output logic [DATA_WIDTH-1:0]     o_i_data,
    input  logic                      i_d_req,
    input  logic                      i_d_write,
    input  logic [MEM_ADDR_WIDTH-1:0] i_d_addr,
    input  logic [DATA_WIDTH/8-1:0]   i_d_sel,
    input  logic [DATA_WIDTH-1:0]     i_d_data,
    output logic                      o_d_stall,
    output logic                      o_d_ack,
    output logic                      o_d_err,
    output logic [DATA_WIDTH-1:0]     o_d_data
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

    logic                      w_i_grant;
    logic                      w_d_grant;
    logic [MEM_ADDR_WIDTH-1:0] w_addr;
    logic                      w_wr;
    logic                      w_d_rd;
    logic [DATA_WIDTH-1:0]     w_rd_word;

    logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
    logic                      r_i_ack;
    logic                      r_d_ack;
    logic [DATA_WIDTH-1:0]     r_i_data;
    logic [DATA_WIDTH-1:0]     r_d_data;

    tcm_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_i_req   (i_i_req),
        .i_d_req   (i_d_req),
        .o_i_grant (w_i_grant),
        .o_d_grant (w_d_grant)
    );

    assign o_i_stall = i_i_req & ~w_i_grant;
    assign o_d_stall = i_d_req & ~w_d_grant;

    assign w_addr    = w_d_grant ? i_d_addr : i_i_addr;
    assign w_wr      = w_d_grant & i_d_write;
    assign w_d_rd    = w_d_grant & ~i_d_write;
    assign w_rd_word = r_mem[w_addr];

    // Array is never reset; grants are already suppressed during reset.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (i_d_sel[k]) begin
                    r_mem[w_addr][8*k +: 8] <= i_d_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_i_ack  <= 1'b0;
            r_d_ack  <= 1'b0;
            r_i_data <= '0;
            r_d_data <= '0;
        end else begin
            r_i_ack <= w_i_grant;
            r_d_ack <= w_d_grant;
            if (w_i_grant) begin
                r_i_data <= w_rd_word;
            end
            if (w_d_rd) begin
                r_d_data <= w_rd_word;
            end
        end
    end

    // Reset masks completions immediately, dropping an ack already in flight.
    assign o_i_ack  = r_i_ack & ~i_reset;
    assign o_d_ack  = r_d_ack & ~i_reset;
    assign o_i_data = i_reset ? '0 : r_i_data;
    assign o_d_data = i_reset ? '0 : r_d_data;

`ifdef TCM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_wr_par;
    logic [NB-1:0] w_rd_par;
    logic          w_rd_err;
    logic          r_i_err;
    logic          r_d_err;

    always_comb begin
        w_wr_par = '0;
        w_rd_par = '0;
        for (int k = 0; k < NB; k++) begin
            w_wr_par[k] = byte_parity(i_d_data[8*k +: 8]);
            w_rd_par[k] = byte_parity(w_rd_word[8*k +: 8]);
        end
    end

    assign w_rd_err = |(r_par[w_addr] ^ w_rd_par);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (i_d_sel[k]) begin
                    r_par[w_addr][k] <= w_wr_par[k];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_i_err <= 1'b0;
            r_d_err <= 1'b0;
        end else begin
            r_i_err <= w_i_grant & w_rd_err;
            r_d_err <= w_d_rd & w_rd_err;
        end
    end

    assign o_i_err = r_i_err & ~i_reset;
    assign o_d_err = r_d_err & ~i_reset;
`else
    assign o_i_err = 1'b0;
    assign o_d_err = 1'b0;
`endif

endmodule

// File: doc/tcm_dual.md
TCM_DUAL -- requirements
Module: tcm_dual

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 8: word-address width; depth = 2**MEM_ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width; a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
REQ-003 SHALL have parameter STARVE_MAX, default 4: consecutive instruction-port losses before forced instruction priority; range 1..15.
REQ-004 SHALL have one clock; reset is synchronous and active-high: i_clk  in  1  rising-edge clock; i_reset  in  1  synchronous active-high reset.
REQ-005 SHALL have i_i_req  in  1  instruction read request.
REQ-006 SHALL have i_i_addr  in  MEM_ADDR_WIDTH  instruction word address.
REQ-007 SHALL have o_i_stall  out  1  request not accepted this cycle (combinational).
REQ-008 SHALL have o_i_ack / o_i_err / o_i_data  out  1/1/DATA_WIDTH  completion pulse, parity error, read data.
REQ-009 SHALL have i_d_req / i_d_write  in  1/1  data request, write qualifier.
REQ-010 SHALL have i_d_addr / i_d_sel / i_d_data  in  MEM_ADDR_WIDTH/NB/DATA_WIDTH  data word address, byte enables, write data.
REQ-011 SHALL have o_d_stall / o_d_ack / o_d_err / o_d_data  out  1/1/1/DATA_WIDTH  as for the instruction port.

Function
REQ-012 SHALL hold one single-port array; at most one access (grant) per cycle.
REQ-013 SHALL accept a port's request in a cycle where req=1 and stall=0; stall = req & ~grant.
REQ-014 SHALL pulse ack for exactly one cycle, the cycle after acceptance; back-to-back accepts give ack on consecutive cycles.
REQ-015 SHALL grant a lone requester unconditionally.
REQ-016 SHALL, on conflict, grant data port unless starvation counter == STARVE_MAX, then grant instruction port.
REQ-017 SHALL increment the starvation counter (4 bits) on each conflict cycle the instruction port loses; clear it on any instruction grant.
REQ-018 SHALL, on accepted write, update only lanes with i_d_sel[k]=1; sel=0 write is accepted and acked, array unchanged.
REQ-019 SHALL, on accepted read, present array word on o_*_data with ack; o_*_data holds until the port's next read ack.
REQ-020 SHALL leave o_d_data unchanged on a write ack.
REQ-021 SHALL return written data on a read accepted the cycle after a write to the same address (no stale read).
REQ-022 SHALL keep o_*_err = 0 except as per REQ-027.

Reset
REQ-023 SHALL, while i_reset=1, force o_i_ack, o_d_ack, o_i_err, o_d_err, starvation counter to 0; o_i_data, o_d_data to 0; stall outputs = req.
REQ-024 SHALL suppress any write presented during a reset cycle; array contents are not cleared by reset.
REQ-025 SHALL drop the ack of an access accepted the cycle before reset asserts.

Configuration
REQ-026 SHALL use macro TCM_PARITY_EN.
REQ-027 SHALL, with TCM_PARITY_EN, store one even-parity bit per byte lane (written with that lane); on read ack assert o_*_err if any lane mismatches; data still returned.
REQ-028 SHALL, without TCM_PARITY_EN, store no parity bits and tie o_i_err, o_d_err to 0.

Structure
REQ-029 SHALL place in package tcm_pkg: default parameter constants, starvation-counter width, byte-parity function.
REQ-030 SHALL split the arbiter and starvation counter into sub-module tcm_arb; array and read/write datapath in tcm_dual.

Verification
REQ-031 SHALL cover: D write addr 0x10 data 0xA5A5_5A5A sel 4'b1111, then I read 0x10 -> o_i_ack next cycle, o_i_data 0xA5A5_5A5A.
REQ-032 SHALL cover: write 0xFFFF_FFFF, then sel 4'b0010 write 0x0000_0000 same addr, D read -> 0xFFFF_00FF.
REQ-033 SHALL cover: both req held continuously, STARVE_MAX=4 -> D granted 4 cycles, I granted 5th, pattern repeats; o_i_stall low only on I-grant cycles.
REQ-034 SHALL cover: D write at cycle n, I read same addr at n+1 -> new data returned.
REQ-035 SHALL cover: i_reset asserted cycle after acceptance -> no ack; write during reset leaves word unchanged.
REQ-036 SHALL cover: with TCM_PARITY_EN, force a stored parity bit flipped -> read ack with o_*_err=1; without macro o_*_err stays 0.
